// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, state codes
// and datapath control encodings.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWriteCond;
        logic       pcWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decoder. Optional addi states are
// present only when MC_FSM_ADDI_EN is defined.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    output ctrl_t      o_ctrl
);

    // Every field not driven for a state stays 0; codes 12-15 decode to all zeros.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.irWrite = 1'b1;
                o_ctrl.pcWrite = 1'b1;
                o_ctrl.aluSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                o_ctrl.aluSrcB = SRCB_IMMSH;
                o_ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.regWrite = 1'b1;
                o_ctrl.memToReg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.memWrite = 1'b1;
                o_ctrl.iorD     = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_B;
                o_ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.regWrite = 1'b1;
                o_ctrl.regDst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.aluSrcA     = 1'b1;
                o_ctrl.aluSrcB     = SRCB_B;
                o_ctrl.aluOp       = ALUOP_SUB;
                o_ctrl.pcWriteCond = 1'b1;
                o_ctrl.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pcWrite  = 1'b1;
                o_ctrl.pcSource = PCSRC_JUMP;
            end
`ifdef MC_FSM_ADDI_EN
            S_ADDIEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_IMM;
                o_ctrl.aluOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.regWrite = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and the
// control decoder. Define MC_FSM_ADDI_EN to add the addi execute/write-back states.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_op,
    output logic [3:0] cur_state,
    output logic [3:0] next_state,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    // The opcode only steers the sequence in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_FSM_ADDI_EN
                    OP_ADDI:      w_next = S_ADDIEX;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (i_op)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMRD: w_next = S_MEMWB;
            S_EXEC:  w_next = S_RWB;
`ifdef MC_FSM_ADDI_EN
            S_ADDIEX: w_next = S_ADDIWB;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    mc_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign cur_state   = r_state;
    assign next_state  = w_next;
    assign PCWriteCond = w_ctrl.pcWriteCond;
    assign PCWrite     = w_ctrl.pcWrite;
    assign IorD        = w_ctrl.iorD;
    assign MemRead     = w_ctrl.memRead;
    assign MemWrite    = w_ctrl.memWrite;
    assign MemtoReg    = w_ctrl.memToReg;
    assign IRWrite     = w_ctrl.irWrite;
    assign PCSource    = w_ctrl.pcSource;
    assign ALUOp       = w_ctrl.aluOp;
    assign ALUSrcB     = w_ctrl.aluSrcB;
    assign ALUSrcA     = w_ctrl.aluSrcA;
    assign RegWrite    = w_ctrl.regWrite;
    assign RegDst      = w_ctrl.regDst;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instruction walks plus random
// opcodes and resets checked every cycle against an instruction-path model.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [5:0] i_op  = OP_BAD;
    logic [3:0] cur_state, next_state;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_op        (i_op),
        .cur_state   (cur_state),
        .next_state  (next_state),
        .PCWriteCond (PCWriteCond),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] dutWord;
    assign dutWord = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

    function automatic logic [15:0] mk(input logic pcwc, input logic pcw, input logic iord,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic irw, input logic [1:0] pcs,
                                       input logic [1:0] aop, input logic [1:0] srcb,
                                       input logic srca, input logic rw, input logic rd);
        return {pcwc, pcw, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
    endfunction

    // Expected control word per state code, written straight from the state table.
    logic [15:0] expWord [16];
    initial begin
        for (int i = 0; i < 16; i++) expWord[i] = '0;
        expWord[0]  = mk(0,1,0,1,0,0,1,2'b00,2'b00,2'b01,0,0,0);
        expWord[1]  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,0,0,0);
        expWord[2]  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
        expWord[3]  = mk(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0);
        expWord[4]  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0);
        expWord[5]  = mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0,0,0);
        expWord[6]  = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,0);
        expWord[7]  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1);
        expWord[8]  = mk(1,0,0,0,0,0,0,2'b01,2'b01,2'b00,1,0,0);
        expWord[9]  = mk(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,0,0,0);
`ifdef MC_FSM_ADDI_EN
        expWord[10] = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
        expWord[11] = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
`endif
    end

    // Model: each instruction is a fixed walk of phases chosen by its opcode.
    function automatic int firstPhase(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 2;
        if (op == OP_R)   return 6;
        if (op == OP_BEQ) return 8;
        if (op == OP_J)   return 9;
`ifdef MC_FSM_ADDI_EN
        if (op == OP_ADDI) return 10;
`endif
        return 0;
    endfunction

    function automatic int modelNext(input int s, input logic [5:0] op);
        int follow [16];
        for (int i = 0; i < 16; i++) follow[i] = 0;
        follow[0] = 1;
        follow[3] = 4;
        follow[6] = 7;
`ifdef MC_FSM_ADDI_EN
        follow[10] = 11;
`endif
        if (s == 1) return firstPhase(op);
        if (s == 2) return (op == OP_LW) ? 3 : ((op == OP_SW) ? 5 : 0);
        return follow[s];
    endfunction

    int mState = 0;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) mState = 0;
        else       mState = modelNext(mState, i_op);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model while out of reset.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            checkOutput("curState", 32'(cur_state), 32'(mState));
            checkOutput("nextState", 32'(next_state), 32'(modelNext(mState, i_op)));
            checkOutput("ctrlWord", 32'(dutWord), 32'(expWord[mState]));
        end
    end

    task automatic applyStimulus(input logic [5:0] op);
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        i_op = op;
        #2 i_rst = 1'b0;
    endtask

    task automatic runInstr(input string tag, input logic [5:0] op, input int path[$],
                            input int spotIdx, input logic [15:0] spotWord);
        applyStimulus(op);
        for (int k = 0; k < path.size(); k++) begin
            if (k > 0) @(negedge i_clk);
            checkOutput({tag, "_state"}, 32'(cur_state), 32'(path[k]));
            if (k == spotIdx) checkOutput({tag, "_ctrl"}, 32'(dutWord), 32'(spotWord));
        end
    endtask

    initial begin
        logic [31:0] rnd;
        #3;
        checkOutput("rstState", 32'(cur_state), 32'd0);
        checkOutput("rstCtrl", 32'(dutWord), 32'(mk(0,1,0,1,0,0,1,2'b00,2'b00,2'b01,0,0,0)));
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checkOutput("unknownLoop", 32'(cur_state), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        runInstr("lw",  OP_LW,  '{0,1,2,3,4,0}, 4, mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0));
        runInstr("sw",  OP_SW,  '{0,1,2,5,0},   3, mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0,0,0));
        runInstr("rt",  OP_R,   '{0,1,6,7,0},   2, mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,0));
        runInstr("rwb", OP_R,   '{0,1,6,7,0},   3, mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1));
        runInstr("beq", OP_BEQ, '{0,1,8,0},     2, mk(1,0,0,0,0,0,0,2'b01,2'b01,2'b00,1,0,0));
        runInstr("j",   OP_J,   '{0,1,9,0},     2, mk(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,0,0,0));
`ifdef MC_FSM_ADDI_EN
        runInstr("addi", OP_ADDI, '{0,1,10,11,0}, 2, mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0));
`else
        runInstr("addi", OP_ADDI, '{0,1,0,1}, 1, mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,0,0,0));
`endif

        // Abort a load in MEMRD: state must drop to FETCH before the next edge.
        runInstr("lwAbort", OP_LW, '{0,1,2,3}, 3, mk(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0));
        #1 i_rst = 1'b1;
        #1;
        checkOutput("asyncRstState", 32'(cur_state), 32'd0);
        checkOutput("asyncRstCtrl", 32'(dutWord), 32'(mk(0,1,0,1,0,0,1,2'b00,2'b00,2'b01,0,0,0)));
        #1 i_rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            @(negedge i_clk);
            #1;
            rnd = $urandom();
            case ($urandom_range(0, 7))
                0: i_op = OP_R;
                1: i_op = OP_LW;
                2: i_op = OP_SW;
                3: i_op = OP_BEQ;
                4: i_op = OP_J;
                5: i_op = OP_ADDI;
                default: i_op = rnd[5:0];
            endcase
            if ($urandom_range(0, 39) == 0) begin
                i_rst = 1'b1;
                #2 i_rst = 1'b0;
            end
        end

        @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
